// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and widths for the 10-bit processor program feeder
package proc_pkg;

    localparam int WORD_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        DRAIN = 3'd3,
        END   = 3'd4
    } stream_state_t;

endpackage

// File: rtl/half_period_timer.sv
// rtl/half_period_timer.sv - phase timer pulsing expire once every HALF enabled cycles
module half_period_timer #(
    parameter int  HALF = 500000,
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    logic [CW-1:0] r_count;

    assign o_expire = i_en && (r_count == CW'(HALF - 1));

    // Count enabled cycles; wrap to zero on expire so back-to-back phases stay exactly HALF long
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clr || o_expire) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/prog_streamer.sv
// rtl/prog_streamer.sv - stored-program feeder driving processor data input and step clock
module prog_streamer
    import proc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int HALF  = 500000
) (
    input  logic              CLK50M,
    input  logic              RSTn,
    input  logic              WE,
    input  logic [AW-1:0]     WADDR,
    input  logic [WORD_W-1:0] WDATA,
    input  logic [AW:0]       LEN,
    input  logic              START,
    input  logic              IRIN,
    input  logic              EXT,
    input  logic              DONE_IN,
    output logic [WORD_W-1:0] D_OUT,
    output logic              STEP_CLK,
    output logic [AW-1:0]     PC,
    output logic              BUSY,
    output logic              FINISHED
);

    stream_state_t     r_state;
    logic [AW-1:0]     r_pc;
    logic [AW:0]       r_len;
    logic              r_take;
    logic              r_fin;
    logic              r_drain_hi;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_expire;
    logic [AW:0]       w_len_clamped;
    logic [AW:0]       w_last_idx;
    logic              w_at_last;

    assign w_busy        = (r_state == LOW) || (r_state == HIGH) || (r_state == DRAIN);
    assign w_len_clamped = (LEN > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : LEN;
    assign w_last_idx    = r_len - (AW+1)'(1);
    assign w_at_last     = ({1'b0, r_pc} == w_last_idx);

    // Timer is held at zero whenever no run is active, so a start always begins a full phase
    half_period_timer #(
        .HALF (HALF)
    ) u_timer (
        .i_clk    (CLK50M),
        .i_rstn   (RSTn),
        .i_en     (w_busy),
        .i_clr    (!w_busy),
        .o_expire (w_expire)
    );

    // Program memory: loadable only between runs so the presented word cannot change under the processor
    always_ff @(posedge CLK50M) begin
        if (WE && !w_busy) begin
            r_mem[WADDR] <= WDATA;
        end
    end

    // Step sequencer: LOW/HIGH halves of each step, PC advance on consumption, drain until done
    always_ff @(posedge CLK50M) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_take     <= 1'b0;
            r_fin      <= 1'b0;
            r_drain_hi <= 1'b0;
        end else begin
            case (r_state)
                IDLE, END: begin
                    if (START) begin
                        r_pc       <= '0;
                        r_drain_hi <= 1'b0;
                        if (LEN == '0) begin
                            r_state <= END;
                        end else begin
                            r_len   <= w_len_clamped;
                            r_state <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_expire) begin
                        r_take  <= IRIN | EXT;
                        r_fin   <= DONE_IN;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_expire) begin
                        if (r_take && w_at_last) begin
                            r_state <= DRAIN;
                        end else begin
                            if (r_take) begin
                                r_pc <= r_pc + AW'(1);
                            end
                            r_state <= LOW;
                        end
                    end
                end
                DRAIN: begin
                    // A done seen together with the last fetch does not count; only drain-phase samples do
                    if (w_expire) begin
                        if (!r_drain_hi) begin
                            r_fin      <= DONE_IN;
                            r_drain_hi <= 1'b1;
                        end else begin
                            r_drain_hi <= 1'b0;
                            if (r_fin) begin
                                r_state <= END;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign D_OUT    = ((r_state == LOW) || (r_state == HIGH)) ? r_mem[r_pc] : '0;
    assign STEP_CLK = (r_state == HIGH) || ((r_state == DRAIN) && r_drain_hi);
    assign PC       = r_pc;
    assign BUSY     = w_busy;
    assign FINISHED = (r_state == END);

endmodule
